// File: rtl/sws_input_cond.sv
// sws_input_cond
//
// Conditions raw mechanical switch pins for the sws register slave:
// two-flop synchronizer, per-bit debounce counter, registered edge
// pulses, sticky change flags and an optional level interrupt.
//
// Optional feature macro: SWS_IRQ_EN
//   defined   -> irq is a register of |(evt_status & irq_mask)
//   undefined -> irq is tied low and irq_mask is ignored
//
// Parameters
//   NUM_SW     number of switch inputs (1..32)
//   DB_CYCLES  debounce hold time in ACLK cycles (>= 1)
//
// Ports
//   ACLK        in   clock, all state on the rising edge
//   ARESET      in   asynchronous active-high reset
//   sw_in       in   raw asynchronous switch pins
//   evt_clr     in   write-1-to-clear strobe for evt_status (one cycle)
//   irq_mask    in   per-bit interrupt enable
//   sw_state    out  debounced switch levels
//   sw_rise     out  one-cycle pulse on debounced 0->1
//   sw_fall     out  one-cycle pulse on debounced 1->0
//   evt_status  out  sticky change flags
//   irq         out  level interrupt
module sws_input_cond #(
  parameter int NUM_SW    = 8,
  parameter int DB_CYCLES = 1000000
) (
  input  logic              ACLK,
  input  logic              ARESET,
  input  logic [NUM_SW-1:0] sw_in,
  input  logic [NUM_SW-1:0] evt_clr,
  input  logic [NUM_SW-1:0] irq_mask,
  output logic [NUM_SW-1:0] sw_state,
  output logic [NUM_SW-1:0] sw_rise,
  output logic [NUM_SW-1:0] sw_fall,
  output logic [NUM_SW-1:0] evt_status,
  output logic              irq
);

  localparam int CW = $clog2(DB_CYCLES + 1);
  // Counter value on which a still-differing input is accepted.
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic [NUM_SW-1:0] sync1_q, sync1_d;
  logic [NUM_SW-1:0] sync2_q, sync2_d;
  logic [NUM_SW-1:0] sw_state_q, sw_state_d;
  logic [NUM_SW-1:0] sw_rise_q, sw_rise_d;
  logic [NUM_SW-1:0] sw_fall_q, sw_fall_d;
  logic [NUM_SW-1:0] evt_q, evt_d;
  logic [CW-1:0]     cnt_q [NUM_SW];
  logic [CW-1:0]     cnt_d [NUM_SW];

  always_comb begin
    sync1_d    = sw_in;
    sync2_d    = sync1_q;
    sw_state_d = sw_state_q;
    sw_rise_d  = '0;
    sw_fall_d  = '0;
    for (int i = 0; i < NUM_SW; i++) begin
      // Any cycle where the synchronized input agrees with the debounced
      // level restarts the hold time, so short excursions are dropped.
      cnt_d[i] = '0;
      if (sync2_q[i] != sw_state_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          sw_state_d[i] = sync2_q[i];
          sw_rise_d[i]  = sync2_q[i];
          sw_fall_d[i]  = ~sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_ONE;
        end
      end
    end
    // Flags are set from the registered pulses; a set beats a clear
    // arriving in the same cycle so no change is ever lost.
    evt_d = (evt_q & ~evt_clr) | sw_rise_q | sw_fall_q;
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      sw_state_q <= '0;
      sw_rise_q  <= '0;
      sw_fall_q  <= '0;
      evt_q      <= '0;
      for (int i = 0; i < NUM_SW; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      sw_state_q <= sw_state_d;
      sw_rise_q  <= sw_rise_d;
      sw_fall_q  <= sw_fall_d;
      evt_q      <= evt_d;
      for (int i = 0; i < NUM_SW; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign sw_state   = sw_state_q;
  assign sw_rise    = sw_rise_q;
  assign sw_fall    = sw_fall_q;
  assign evt_status = evt_q;

`ifdef SWS_IRQ_EN
  logic irq_q, irq_d;

  always_comb begin
    irq_d = |(evt_q & irq_mask);
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= irq_d;
    end
  end

  assign irq = irq_q;
`else
  // Interrupt disabled: the mask input is intentionally left unused.
  logic unused_irq_mask;
  assign unused_irq_mask = ^irq_mask;
  assign irq = 1'b0;
`endif

endmodule

// File: doc/sws_input_cond.md
SWS_INPUT_COND -- requirements
Module: sws_input_cond

Interface
REQ-001 SHALL have parameter NUM_SW, default 8, number of switch inputs (1..32).
REQ-002 SHALL have parameter DB_CYCLES, default 1000000, debounce hold time in ACLK cycles (>=1; 10 ms at 100 MHz).
REQ-003 SHALL have port ACLK  input  1  single clock; all state on its rising edge.
REQ-004 SHALL have port ARESET  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port sw_in  input  NUM_SW  raw asynchronous switch pins.
REQ-006 SHALL have port evt_clr  input  NUM_SW  write-1-to-clear strobe from the register slave, one cycle.
REQ-007 SHALL have port irq_mask  input  NUM_SW  per-bit interrupt enable.
REQ-008 SHALL have port sw_state  output  NUM_SW  debounced switch levels, feeds the sws slave read register.
REQ-009 SHALL have port sw_rise  output  NUM_SW  one-cycle pulse per bit on debounced 0->1.
REQ-010 SHALL have port sw_fall  output  NUM_SW  one-cycle pulse per bit on debounced 1->0.
REQ-011 SHALL have port evt_status  output  NUM_SW  sticky change flags, feeds the sws slave status register.
REQ-012 SHALL have port irq  output  1  level interrupt.

Function
REQ-013 SHALL pass each sw_in bit through a 2-flop synchronizer (sync1, sync2) before any other use.
REQ-014 SHALL keep one counter per bit, width $clog2(DB_CYCLES+1), saturating never (cleared before overflow).
REQ-015 SHALL, per bit, clear the counter in any cycle where sync2 equals sw_state.
REQ-016 SHALL, per bit, increment the counter in any cycle where sync2 differs from sw_state and counter < DB_CYCLES-1.
REQ-017 SHALL, per bit, when sync2 differs and counter == DB_CYCLES-1, load sw_state <= sync2 and clear the counter on that edge.
REQ-018 SHALL give latency: sw_in change held steady, registered at edge N, appears on sw_state at edge N+1+DB_CYCLES.
REQ-019 SHALL ignore any sync2 excursion shorter than DB_CYCLES consecutive cycles (counter restarts from 0 on return).
REQ-020 SHALL assert sw_rise/sw_fall registered, in exactly the cycle sw_state first shows the new value, for one cycle.
REQ-021 SHALL set evt_status[i] on sw_rise[i] or sw_fall[i]; clear it on evt_clr[i]; set wins when both occur in the same cycle.
REQ-022 SHALL treat bits independently; simultaneous changes on several bits produce simultaneous pulses and flags.
REQ-023 SHALL leave evt_clr on an already-clear bit with no effect.

Reset
REQ-024 SHALL, on ARESET high, asynchronously clear sync1, sync2, counters, sw_state, sw_rise, sw_fall, evt_status and irq to 0.
REQ-025 SHALL hold all state at reset values while ARESET is high; a debounce in progress is discarded.
REQ-026 SHALL, for a switch held high through reset, report a rise (pulse and evt_status) 1+DB_CYCLES edges after the first post-reset sampling edge.

Configuration
REQ-027 SHALL, with macro SWS_IRQ_EN defined, drive irq as a register of |(evt_status & irq_mask), one cycle after evt_status.
REQ-028 SHALL, without SWS_IRQ_EN, tie irq to 0, leave irq_mask unused, and keep all other behaviour identical.

Verification (DB_CYCLES=4, NUM_SW=8)
REQ-029 SHALL cover: reset, sw_in=0x00, set sw_in=0x01 held -> sw_state=0x01 and sw_rise=0x01 for one cycle 5 edges after capture; evt_status=0x01.
REQ-030 SHALL cover: sw_in[1] high for 3 cycles then low -> sw_state, sw_rise, evt_status unchanged.
REQ-031 SHALL cover: evt_status=0x01, evt_clr=0x01 in same cycle as new sw_fall[0] -> evt_status stays 0x01; next evt_clr=0x01 -> 0x00.
REQ-032 SHALL cover: sw_in 0x00->0xA5 -> sw_rise=0xA5 in one cycle, sw_state=0xA5; then 0xA5->0x00 -> sw_fall=0xA5.
REQ-033 SHALL cover (SWS_IRQ_EN): irq_mask=0x04, bit 2 rises -> irq=1 one cycle after evt_status[2]; evt_clr=0x04 -> irq=0; irq_mask=0x00 -> irq never asserts.
REQ-034 SHALL cover: ARESET pulsed mid-debounce (counter=2) -> all outputs 0 immediately, no pulse from the aborted debounce.
